// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side slave for the cache miss/refill interface.
// A word-addressed internal memory answers line refills (4 beats) and single
// word reads after RD_LAT idle cycles. Writes (line or masked word) are
// captured in one cycle and committed one word per cycle.
//
// Handshakes: a read transfer happens on a rising edge where rd_req & rd_rdy;
// rd_req is held by the requester until then. A write is a one-cycle wr_req
// pulse, captured only when wr_rdy is high in that same cycle; a pulse seen
// while wr_rdy is low is dropped and flagged on the sticky proto_err.
// Read data beats have no back-pressure: ret_valid marks each beat and
// ret_last marks the final one.
module cache_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         proto_err
);

  localparam int DEPTH = 1 << ADDR_W;
  // Wait-state count loaded on acceptance; RD_LAT 0 and 1 skip R_WAIT.
  localparam logic [3:0] LAT_LOAD = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_t;
  typedef enum logic {W_IDLE, W_COMMIT} w_state_t;

  logic [31:0] mem [DEPTH];

  // Read engine state
  r_state_t          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_idx_q, r_idx_d;
  logic [2:0]        r_left_q, r_left_d;
  logic [3:0]        r_lat_q, r_lat_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_last_q, ret_last_d;
  logic [31:0]       ret_data_q, ret_data_d;

  // Write engine state
  w_state_t          w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [1:0]        w_cnt_q, w_cnt_d;
  logic              w_line_q, w_line_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic [127:0]      w_data_q, w_data_d;
  logic              proto_err_q, proto_err_d;

  logic              rd_accept, wr_accept;
  logic              rd_line;
  logic [ADDR_W-1:0] rd_base;
  logic [2:0]        rd_beats;
  logic              issue, issue_last;
  logic [ADDR_W-1:0] issue_idx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;

  // Address bits outside the word index alias and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                              wr_addr[31:ADDR_W+2], wr_addr[1:0]};

  // Ready decode: the write side always wins, and reads wait for commits.
  assign wr_rdy    = (w_state_q == W_IDLE) & ~reset;
  assign rd_rdy    = (r_state_q == R_IDLE) & (w_state_q == W_IDLE) & ~wr_req & ~reset;
  assign rd_accept = rd_req & rd_rdy;
  assign wr_accept = wr_req & wr_rdy;

  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;
  assign proto_err = proto_err_q;

  // Read FSM next state and beat issue; a beat samples memory when issued.
  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_left_d   = r_left_q;
    r_lat_d    = r_lat_q;
    issue      = 1'b0;
    issue_idx  = r_idx_q;
    issue_last = 1'b0;
    rd_line    = (rd_type == 3'b100);
    rd_base    = rd_line ? {rd_addr[ADDR_W+1:4], 2'b00} : rd_addr[ADDR_W+1:2];
    rd_beats   = rd_line ? 3'd4 : 3'd1;
    case (r_state_q)
      R_IDLE: begin
        if (rd_accept) begin
          if (RD_LAT == 0) begin
            issue      = 1'b1;
            issue_idx  = rd_base;
            issue_last = (rd_beats == 3'd1);
            r_idx_d    = rd_base + ADDR_W'(1);
            r_left_d   = rd_beats - 3'd1;
            r_state_d  = R_BEAT;
          end else begin
            r_idx_d   = rd_base;
            r_left_d  = rd_beats;
            r_lat_d   = LAT_LOAD;
            r_state_d = (RD_LAT == 1) ? R_BEAT : R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_lat_q == 4'd0) r_state_d = R_BEAT;
        else                 r_lat_d   = r_lat_q - 4'd1;
      end
      R_BEAT: begin
        // left==0 is the cycle the final beat is on the bus; idle after it.
        if (r_left_q == 3'd0) begin
          r_state_d = R_IDLE;
        end else begin
          issue      = 1'b1;
          issue_idx  = r_idx_q;
          issue_last = (r_left_q == 3'd1);
          r_idx_d    = r_idx_q + ADDR_W'(1);
          r_left_d   = r_left_q - 3'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ret_valid_d = issue;
    ret_last_d  = issue & issue_last;
    ret_data_d  = issue ? mem[issue_idx] : 32'd0;
  end

  // Read engine registers; reset drops any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      r_left_q    <= '0;
      r_lat_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_left_q    <= r_left_d;
      r_lat_q     <= r_lat_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
    end
  end

  // Write FSM: capture on wr_accept, then commit one word per cycle.
  always_comb begin
    w_state_d   = w_state_q;
    w_base_d    = w_base_q;
    w_cnt_d     = w_cnt_q;
    w_line_d    = w_line_q;
    w_strb_d    = w_strb_q;
    w_data_d    = w_data_q;
    proto_err_d = proto_err_q | (wr_req & ~wr_rdy);
    mem_we      = 1'b0;
    mem_widx    = w_base_q + ADDR_W'(w_cnt_q);
    mem_wstrb   = w_line_q ? 4'hF : w_strb_q;
    mem_wdata   = w_data_q[32*w_cnt_q +: 32];
    case (w_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          w_line_d  = (wr_type == 3'b100);
          w_base_d  = (wr_type == 3'b100) ? {wr_addr[ADDR_W+1:4], 2'b00}
                                          : wr_addr[ADDR_W+1:2];
          w_cnt_d   = 2'd0;
          w_strb_d  = wr_wstrb;
          w_data_d  = wr_data;
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        // A commit coinciding with reset is suppressed so reset aborts cleanly.
        mem_we = ~reset;
        if (w_cnt_q == (w_line_q ? 2'd3 : 2'd0)) w_state_d = W_IDLE;
        else                                     w_cnt_d   = w_cnt_q + 2'd1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine registers and the sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      w_base_q    <= '0;
      w_cnt_q     <= '0;
      w_line_q    <= 1'b0;
      w_strb_q    <= '0;
      w_data_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      w_base_q    <= w_base_d;
      w_cnt_q     <= w_cnt_d;
      w_line_q    <= w_line_d;
      w_strb_q    <= w_strb_d;
      w_data_q    <= w_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Byte-masked memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule
